hazard_ctrl: RTL

- Parametrised successor to the pipeline's load-use stall generator. Detects RAW hazards between the instruction in ID and a load in EX.
- Holds PC and IF/ID for a configurable number of cycles and inserts bubbles into ID/EX.
- Adds control-hazard flushing, a whole-pipeline freeze for memory wait-states, and a saturating stall counter.
- Uses enable signals instead of gated clocks. Sits between the decode stage and the pipeline registers.

---
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Load-use hazard, control-flush and memory-freeze controller for the in-order pipeline.
// Produces register enables/flushes and a saturating count of load-use stall cycles.
module hazard_ctrl #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic                  ex_mem_rd_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  branch_taken_i,
    input  logic                  mem_busy_i,
    output logic                  pc_en_o,
    output logic                  if_id_en_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_en_o,
    output logic                  id_ex_flush_o,
    output logic                  stall_active_o,
    output logic [CNT_W-1:0]      stall_count_o
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_e;

    localparam logic [2:0]       REM_INIT = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [2:0]       rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hz_s;

    // RAW hazard between the ID sources and a load in EX; x0 and unused sources never match.
    always_comb begin
        hz_s = ex_mem_rd_i && (ex_rd_i != {REG_ADDR_W{1'b0}}) &&
               ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                (id_rs2_used_i && (id_rs2_i == ex_rd_i)));
    end

    // Output decode in priority order plus next-state, remaining-bubble and counter update.
    always_comb begin
        pc_en_o        = 1'b1;
        if_id_en_o     = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_en_o     = 1'b1;
        id_ex_flush_o  = 1'b0;
        stall_active_o = 1'b0;
        state_d        = state_q;
        rem_d          = rem_q;
        cnt_d          = cnt_q;

        if (!rst_n_i) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            state_d       = IDLE;
            rem_d         = 3'd0;
            cnt_d         = {CNT_W{1'b0}};
        end else if (mem_busy_i) begin
            // Freeze: nothing moves, STALL progress and counter are preserved.
            pc_en_o    = 1'b0;
            if_id_en_o = 1'b0;
            id_ex_en_o = 1'b0;
        end else if (branch_taken_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            state_d       = IDLE;
            rem_d         = 3'd0;
        end else if ((state_q == STALL) || hz_s) begin
            pc_en_o        = 1'b0;
            if_id_en_o     = 1'b0;
            id_ex_flush_o  = 1'b1;
            stall_active_o = 1'b1;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
            case (state_q)
                IDLE: begin
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d = STALL;
                        rem_d   = REM_INIT;
                    end else begin
                        state_d = IDLE;
                        rem_d   = 3'd0;
                    end
                end
                STALL: begin
                    // hz is ignored here so the release point is fixed at detection time.
                    if (rem_q == 3'd1) begin
                        state_d = IDLE;
                        rem_d   = 3'd0;
                    end else begin
                        state_d = STALL;
                        rem_d   = rem_q - 3'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rem_d   = 3'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State, remaining-bubble and performance-counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            rem_q   <= 3'd0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_count_o = cnt_q;

endmodule
